// File: rtl/in_buffer_pkg.sv
// Shared definitions for the ping-pong particle input buffer.
//   FIELD_X / FIELD_Y / FIELD_MASS : default field order inside a particle record
//   flat_addr()                    : particle/field to flat storage address
package in_buffer_pkg;

  localparam int FIELD_X    = 0;
  localparam int FIELD_Y    = 1;
  localparam int FIELD_MASS = 2;

  // Particles are stored field-interleaved: all F words of particle 0, then
  // particle 1, and so on.
  function automatic int flat_addr(input int idx, input int sel, input int f);
    return idx * f + sel;
  endfunction

endpackage

// File: rtl/in_buffer_bank.sv
// One storage bank of the ping-pong buffer: DEPTH words of W bits.
//   CLK_IN   : clock
//   wr_en    : write strobe, wr_addr/wr_data captured on the rising edge
//   rd_en    : read strobe, rd_data is loaded from rd_addr on the rising edge
//   rd_data  : registered read data, holds its value while rd_en is low
module in_buffer_bank #(
  parameter int W         = 16,
  parameter int DEPTH     = 768,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 CLK_IN,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [W-1:0]         wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [W-1:0]         rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the parent tracks which words are meaningful
  // through its full/count state, so the array maps onto plain RAM.
  always_ff @(posedge CLK_IN) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // independent of statement order.
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/in_buffer_pingpong.sv
// Double-buffered particle input buffer. The host streams F-word particle
// records into the fill bank while the force pipeline reads the completed
// frame in the other bank at random.
//   CLK_IN, RESET_IN           : clock, asynchronous active-high reset
//   DATA_IN/S_VALID/S_READY    : stream handshake; S_LAST closes a frame on a
//                                particle's final field beat
//   CLEAR                      : synchronous flush of both banks
//   FRAME_VALID/FRAME_COUNT    : read bank holds a frame of that many particles
//   RELEASE                    : consumer done with the read bank
//   RD_EN/RD_IDX/RD_SEL        : random read request
//   DATA_OUT/RD_VALID          : read data, one cycle after RD_EN
module in_buffer_pingpong
  import in_buffer_pkg::*;
#(
  parameter int W        = 16,
  parameter int N        = 256,
  parameter int F        = 3,
  parameter int IDX_BITS = $clog2(N),
  parameter int SEL_BITS = (F > 2) ? $clog2(F) : 1,
  parameter int CNT_BITS = $clog2(N + 1)
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic [W-1:0]        DATA_IN,
  input  logic                S_VALID,
  output logic                S_READY,
  input  logic                S_LAST,
  input  logic                CLEAR,
  output logic                FRAME_VALID,
  output logic [CNT_BITS-1:0] FRAME_COUNT,
  input  logic                RELEASE,
  input  logic                RD_EN,
  input  logic [IDX_BITS-1:0] RD_IDX,
  input  logic [SEL_BITS-1:0] RD_SEL,
  output logic [W-1:0]        DATA_OUT,
  output logic                RD_VALID
);

  localparam int DEPTH     = N * F;
  localparam int ADDR_BITS = $clog2(DEPTH);

  logic                wptr;
  logic                rptr;
  logic [1:0]          full;
  logic [CNT_BITS-1:0] count [2];
  logic [IDX_BITS-1:0] idx;
  logic [SEL_BITS-1:0] fld;

  logic                 wr_fire;
  logic                 last_fld;
  logic                 close_frame;
  logic                 do_release;
  logic                 rd_ok;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [ADDR_BITS-1:0] rd_addr;

  // Read-side pipeline: which bank answered, whether the request was in range.
  logic         rd_bank_q;
  logic         rd_ok_q;
  logic [W-1:0] bank_rdata [2];

  assign S_READY     = ~full[wptr];
  assign FRAME_VALID = full[rptr];
  assign FRAME_COUNT = full[rptr] ? count[rptr] : '0;

  assign wr_fire     = S_VALID & S_READY & ~CLEAR;
  assign last_fld    = (int'(fld) == F - 1);
  assign close_frame = last_fld & (S_LAST | (int'(idx) == N - 1));
  assign do_release  = RELEASE & full[rptr];
  assign wr_addr     = ADDR_BITS'(flat_addr(int'(idx), int'(fld), F));

  // Out-of-range requests never touch storage; they return zero via rd_ok_q.
  assign rd_ok   = full[rptr] & (CNT_BITS'(RD_IDX) < count[rptr]) & (int'(RD_SEL) < F);
  assign rd_addr = ADDR_BITS'(flat_addr(int'(RD_IDX), int'(RD_SEL), F));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    in_buffer_bank #(
      .W         (W),
      .DEPTH     (DEPTH),
      .ADDR_BITS (ADDR_BITS)
    ) u_bank (
      .CLK_IN  (CLK_IN),
      .wr_en   (wr_fire & (wptr == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (DATA_IN),
      .rd_en   (RD_EN & rd_ok & ~CLEAR & (rptr == 1'(b))),
      .rd_addr (rd_addr),
      .rd_data (bank_rdata[b])
    );
  end

  // Fill/read bank bookkeeping. A closing beat and a RELEASE can land in the
  // same cycle: the close always targets the empty fill bank and the release
  // the full read bank, so the two updates never touch the same entry.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      full     <= '0;
      count[0] <= '0;
      count[1] <= '0;
      idx      <= '0;
      fld      <= '0;
    end else if (CLEAR) begin
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      full     <= '0;
      count[0] <= '0;
      count[1] <= '0;
      idx      <= '0;
      fld      <= '0;
    end else begin
      if (wr_fire) begin
        if (last_fld) begin
          fld <= '0;
          if (close_frame) begin
            full[wptr]  <= 1'b1;
            count[wptr] <= CNT_BITS'(idx) + CNT_BITS'(1);
            wptr        <= ~wptr;
            idx         <= '0;
          end else begin
            idx <= idx + IDX_BITS'(1);
          end
        end else begin
          fld <= fld + SEL_BITS'(1);
        end
      end
      if (do_release) begin
        full[rptr] <= 1'b0;
        rptr       <= ~rptr;
      end
    end
  end

  // Bank select and range flag are captured with the request, so a read
  // issued in a RELEASE cycle still returns the pre-release frame.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      RD_VALID  <= 1'b0;
      rd_ok_q   <= 1'b0;
      rd_bank_q <= 1'b0;
    end else if (CLEAR) begin
      RD_VALID  <= 1'b0;
      rd_ok_q   <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      RD_VALID <= RD_EN;
      if (RD_EN) begin
        rd_ok_q   <= rd_ok;
        rd_bank_q <= rptr;
      end
    end
  end

  assign DATA_OUT = rd_ok_q ? bank_rdata[rd_bank_q] : '0;

endmodule

// File: tb/tb_in_buffer_pingpong.sv
// Self-checking bench for in_buffer_pingpong (W=16, N=4, F=3). A frame-level
// model (a two-deep queue of completed frames plus the partial frame being
// streamed) predicts every output; a compare process checks them on each
// falling edge, and directed scenarios pin the model with literal values.
module tb_in_buffer_pingpong;
  import in_buffer_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int F  = 3;
  localparam int NF = N * F;

  logic          CLK_IN;
  logic          RESET_IN;
  logic [W-1:0]  DATA_IN;
  logic          S_VALID;
  logic          S_READY;
  logic          S_LAST;
  logic          CLEAR;
  logic          FRAME_VALID;
  logic [2:0]    FRAME_COUNT;
  logic          RELEASE;
  logic          RD_EN;
  logic [1:0]    RD_IDX;
  logic [1:0]    RD_SEL;
  logic [W-1:0]  DATA_OUT;
  logic          RD_VALID;

  in_buffer_pingpong #(.W(W), .N(N), .F(F)) dut (
    .CLK_IN      (CLK_IN),
    .RESET_IN    (RESET_IN),
    .DATA_IN     (DATA_IN),
    .S_VALID     (S_VALID),
    .S_READY     (S_READY),
    .S_LAST      (S_LAST),
    .CLEAR       (CLEAR),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_COUNT (FRAME_COUNT),
    .RELEASE     (RELEASE),
    .RD_EN       (RD_EN),
    .RD_IDX      (RD_IDX),
    .RD_SEL      (RD_SEL),
    .DATA_OUT    (DATA_OUT),
    .RD_VALID    (RD_VALID)
  );

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Completed frames form a FIFO of depth two (slots mh, mh^1); the head is
  // what the consumer sees. cur_w collects the frame being streamed.
  logic [W-1:0] mframe [2][NF];
  int           mcnt [2];
  int           mh;
  int           msz;
  logic [W-1:0] cur_w [NF];
  int           cur_n;
  logic [W-1:0] exp_dout;
  logic         exp_rv;

  task automatic model_reset();
    msz      = 0;
    mh       = 0;
    cur_n    = 0;
    mcnt[0]  = 0;
    mcnt[1]  = 0;
    exp_dout = '0;
    exp_rv   = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    bit rel;
    int t;
    if (RESET_IN || CLEAR) begin
      model_reset();
      return;
    end
    exp_rv = RD_EN;
    if (RD_EN) begin
      if (msz > 0 && int'(RD_IDX) < mcnt[mh] && int'(RD_SEL) < F)
        exp_dout = mframe[mh][int'(RD_IDX) * F + int'(RD_SEL)];
      else
        exp_dout = '0;
    end
    acc = S_VALID && (msz < 2);
    rel = RELEASE && (msz > 0);
    if (acc) begin
      cur_w[cur_n] = DATA_IN;
      cur_n++;
      if ((cur_n % F == 0) && (cur_n == NF || S_LAST)) begin
        t = (mh + msz) % 2;
        for (int i = 0; i < cur_n; i++) mframe[t][i] = cur_w[i];
        mcnt[t] = cur_n / F;
        msz++;
        cur_n = 0;
      end
    end
    if (rel) begin
      mh ^= 1;
      msz--;
    end
  endtask

  always @(posedge CLK_IN) model_step();

  // One compare process: every output, every cycle once checking is enabled.
  always @(negedge CLK_IN) begin
    if (chk_en) begin
      check("s_ready",     32'(S_READY),     32'(msz < 2));
      check("frame_valid", 32'(FRAME_VALID), 32'(msz > 0));
      check("frame_count", 32'(FRAME_COUNT), (msz > 0) ? 32'(mcnt[mh]) : 32'd0);
      check("rd_valid",    32'(RD_VALID),    32'(exp_rv));
      check("data_out",    32'(DATA_OUT),    32'(exp_dout));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic idle();
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    CLEAR   = 1'b0;
    RELEASE = 1'b0;
    RD_EN   = 1'b0;
    DATA_IN = '0;
    RD_IDX  = '0;
    RD_SEL  = '0;
  endtask

  task automatic cyc();
    @(negedge CLK_IN);
  endtask

  task automatic beat(input logic [W-1:0] d, input logic last);
    S_VALID = 1'b1;
    DATA_IN = d;
    S_LAST  = last;
    cyc();
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
  endtask

  task automatic particle(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] m, input logic last);
    beat(x, 1'b0);
    beat(y, 1'b0);
    beat(m, last);
  endtask

  task automatic rd(input int i, input int s);
    RD_EN  = 1'b1;
    RD_IDX = 2'(i);
    RD_SEL = 2'(s);
    cyc();
    RD_EN  = 1'b0;
  endtask

  task automatic pulse_release();
    RELEASE = 1'b1;
    cyc();
    RELEASE = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    RESET_IN = 1'b0;
    #1;
    RESET_IN = 1'b1;
    model_reset();
    cyc();
    cyc();
    check("rst_s_ready",     32'(S_READY),     32'd1);
    check("rst_frame_valid", 32'(FRAME_VALID), 32'd0);
    check("rst_frame_count", 32'(FRAME_COUNT), 32'd0);
    check("rst_data_out",    32'(DATA_OUT),    32'd0);
    check("rst_rd_valid",    32'(RD_VALID),    32'd0);
    RESET_IN = 1'b0;
    chk_en   = 1'b1;

    // 1: full frame of four particles, closed by reaching N.
    particle(16'h1111, 16'h2222, 16'h3333, 1'b0);
    particle(16'h4444, 16'h5555, 16'h6666, 1'b0);
    particle(16'h7777, 16'h8888, 16'h9999, 1'b0);
    particle(16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b0);
    check("s1_frame_valid", 32'(FRAME_VALID), 32'd1);
    check("s1_frame_count", 32'(FRAME_COUNT), 32'd4);
    check("s1_s_ready",     32'(S_READY),     32'd1);
    rd(1, FIELD_MASS);
    check("s1_data_out", 32'(DATA_OUT), 32'h6666);
    check("s1_rd_valid", 32'(RD_VALID), 32'd1);

    // 2: short frame; S_LAST on a Y beat is ignored.
    pulse_release();
    check("s2_released", 32'(FRAME_VALID), 32'd0);
    beat(16'h0101, 1'b0);
    beat(16'h0202, 1'b1);
    beat(16'h0303, 1'b0);
    particle(16'h0404, 16'h0505, 16'h0606, 1'b1);
    check("s2_frame_count", 32'(FRAME_COUNT), 32'd2);
    rd(3, FIELD_X);
    check("s2_out_of_range", 32'(DATA_OUT), 32'd0);
    rd(0, FIELD_Y);
    check("s2_y_beat", 32'(DATA_OUT), 32'h0202);
    rd(1, 3);
    check("s2_bad_sel", 32'(DATA_OUT), 32'd0);

    // 3: both banks full stalls the stream until RELEASE.
    for (int p = 0; p < 4; p++)
      particle(16'(16'h1000 + p * 16), 16'(16'h1001 + p * 16), 16'(16'h1002 + p * 16), 1'b0);
    check("s3_s_ready_low",  32'(S_READY),     32'd0);
    check("s3_count_kept",   32'(FRAME_COUNT), 32'd2);
    beat(16'hDEAD, 1'b1);
    pulse_release();
    check("s3_count_next",   32'(FRAME_COUNT), 32'd4);
    check("s3_s_ready_high", 32'(S_READY),     32'd1);
    rd(2, FIELD_X);
    check("s3_data", 32'(DATA_OUT), 32'h1020);

    // 4: frame close, RELEASE and a read in the same cycle.
    particle(16'h2000, 16'h2001, 16'h2002, 1'b0);
    particle(16'h2010, 16'h2011, 16'h2012, 1'b0);
    beat(16'h2020, 1'b0);
    beat(16'h2021, 1'b0);
    S_VALID = 1'b1;
    DATA_IN = 16'h2022;
    S_LAST  = 1'b1;
    RELEASE = 1'b1;
    RD_EN   = 1'b1;
    RD_IDX  = 2'd0;
    RD_SEL  = 2'd0;
    cyc();
    idle();
    check("s4_frame_valid", 32'(FRAME_VALID), 32'd1);
    check("s4_frame_count", 32'(FRAME_COUNT), 32'd3);
    check("s4_old_data",    32'(DATA_OUT),    32'h1000);
    rd(2, FIELD_MASS);
    check("s4_new_data", 32'(DATA_OUT), 32'h2022);

    // 5: CLEAR with an accepted beat mid-frame.
    beat(16'h3000, 1'b0);
    beat(16'h3001, 1'b0);
    beat(16'h3002, 1'b0);
    beat(16'h3010, 1'b0);
    S_VALID = 1'b1;
    DATA_IN = 16'h3011;
    CLEAR   = 1'b1;
    cyc();
    idle();
    check("s5_frame_valid", 32'(FRAME_VALID), 32'd0);
    check("s5_frame_count", 32'(FRAME_COUNT), 32'd0);
    check("s5_s_ready",     32'(S_READY),     32'd1);
    check("s5_data_out",    32'(DATA_OUT),    32'd0);
    particle(16'h4444, 16'h4545, 16'h4646, 1'b1);
    check("s5_count_one", 32'(FRAME_COUNT), 32'd1);
    rd(0, FIELD_X);
    check("s5_idx0", 32'(DATA_OUT), 32'h4444);

    // 6: asynchronous reset between edges, mid-frame.
    beat(16'h5000, 1'b0);
    beat(16'h5001, 1'b0);
    S_VALID = 1'b1;
    DATA_IN = 16'h5002;
    RD_EN   = 1'b1;
    RD_IDX  = 2'd0;
    RD_SEL  = 2'd1;
    cyc();
    check("s6_pre_data", 32'(DATA_OUT), 32'h4545);
    #2;
    RESET_IN = 1'b1;
    model_reset();
    #1;
    check("s6_s_ready",     32'(S_READY),     32'd1);
    check("s6_frame_valid", 32'(FRAME_VALID), 32'd0);
    check("s6_frame_count", 32'(FRAME_COUNT), 32'd0);
    check("s6_data_out",    32'(DATA_OUT),    32'd0);
    check("s6_rd_valid",    32'(RD_VALID),    32'd0);
    idle();
    cyc();
    cyc();
    RESET_IN = 1'b0;
    for (int p = 0; p < 4; p++)
      particle(16'(16'h6000 + p * 16), 16'(16'h6001 + p * 16), 16'(16'h6002 + p * 16), 1'b0);
    check("s6_refill_count", 32'(FRAME_COUNT), 32'd4);
    rd(3, FIELD_MASS);
    check("s6_refill_data", 32'(DATA_OUT), 32'h6032);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      S_VALID = ($urandom_range(0, 9) < 7);
      DATA_IN = 16'($urandom);
      S_LAST  = ($urandom_range(0, 4) == 0);
      RELEASE = ($urandom_range(0, 6) == 0);
      RD_EN   = ($urandom_range(0, 1) == 1);
      RD_IDX  = 2'($urandom_range(0, 3));
      RD_SEL  = 2'($urandom_range(0, 3));
      CLEAR   = ($urandom_range(0, 99) == 0);
      cyc();
    end
    idle();
    cyc();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
